qspi_psram_ctrl: RTL

QSPI_PSRAM_CTRL -- requirements
Module: qspi_psram_ctrl

---
 rtl/qspi_psram_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/qspi_psram_ctrl.sv
// QSPI PSRAM controller: one 32-bit read/write per request, quad-enable (0x35) issued after every reset.
// Latency: ack_o 57 clk (read) / 45 clk (write) after accept; ready_o stays low while busy, so req_i is simply held off.
module qspi_psram_ctrl #(
  parameter int DUMMY_CYCLES = 6,
  parameter int CS_HIGH_MIN  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [23:0] adr_i,
  input  logic [31:0] wdat_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdat_o,
  output logic        init_done_o,
  output logic        sck_o,
  output logic        cs_on,
  output logic [3:0]  sio_o,
  output logic [3:0]  sio_oen_o,
  input  logic [3:0]  sio_i
);

  localparam logic [7:0] CMD_QE   = 8'h35;
  localparam logic [7:0] CMD_RD   = 8'hEB;
  localparam logic [7:0] CMD_WR   = 8'h38;
  localparam logic [7:0] DUM_LAST = 8'(2 * DUMMY_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'((CS_HIGH_MIN > 1) ? (CS_HIGH_MIN - 1) : 0);

  typedef enum logic [2:0] {INIT, IDLE, CMD, ADR, DUMMY, WDATA, RDATA, GAP} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic        we_q;
  logic [7:0]  cmd_sr;
  logic [23:0] adr_sr;
  logic [31:0] dat_sr;
  logic [27:0] rd_sr;

  logic [7:0]  acc_cmd;
  logic [31:0] rd_full;
  logic [31:0] wdat_sw;
  logic        serial_active;

  assign acc_cmd = we_i ? CMD_WR : CMD_RD;
  assign rd_full = {rd_sr, sio_i};
  // Byte 0 goes out first, so swap bytes once and then shift MSB nibble first.
  assign wdat_sw = {wdat_i[7:0], wdat_i[15:8], wdat_i[23:16], wdat_i[31:24]};
  assign serial_active = (state == CMD) || (state == ADR) || (state == DUMMY) ||
                         (state == WDATA) || (state == RDATA) || ((state == INIT) && !cs_on);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= INIT;
      cnt         <= 8'd0;
      we_q        <= 1'b0;
      cmd_sr      <= 8'd0;
      adr_sr      <= 24'd0;
      dat_sr      <= 32'd0;
      rd_sr       <= 28'd0;
      cs_on       <= 1'b1;
      sck_o       <= 1'b0;
      sio_o       <= 4'b0000;
      sio_oen_o   <= 4'b0000;
      ack_o       <= 1'b0;
      ready_o     <= 1'b0;
      init_done_o <= 1'b0;
      rdat_o      <= 32'd0;
    end else begin
      ack_o <= 1'b0;
      // Even cnt: sck low, data already set up; odd cnt: sck high, next edge drops it.
      if (serial_active) begin
        sck_o <= ~cnt[0];
        cnt   <= cnt + 8'd1;
      end

      case (state)
        INIT: begin
          if (cs_on) begin
            cs_on     <= 1'b0;
            sck_o     <= 1'b0;
            cnt       <= 8'd0;
            cmd_sr    <= {CMD_QE[6:0], 1'b0};
            sio_o     <= {3'b000, CMD_QE[7]};
            sio_oen_o <= 4'b0001;
          end else if (cnt[0]) begin
            if (cnt == 8'd15) begin
              state       <= GAP;
              cnt         <= 8'd0;
              cs_on       <= 1'b1;
              sio_o       <= 4'b0000;
              sio_oen_o   <= 4'b0000;
              init_done_o <= 1'b1;
            end else begin
              sio_o  <= {3'b000, cmd_sr[7]};
              cmd_sr <= {cmd_sr[6:0], 1'b0};
            end
          end
        end

        IDLE: begin
          if (req_i) begin
            state     <= CMD;
            ready_o   <= 1'b0;
            cnt       <= 8'd0;
            we_q      <= we_i;
            cmd_sr    <= {acc_cmd[6:0], 1'b0};
            adr_sr    <= adr_i;
            dat_sr    <= wdat_sw;
            cs_on     <= 1'b0;
            sck_o     <= 1'b0;
            sio_o     <= {3'b000, acc_cmd[7]};
            sio_oen_o <= 4'b0001;
          end
        end

        CMD: begin
          if (cnt[0]) begin
            if (cnt == 8'd15) begin
              state     <= ADR;
              cnt       <= 8'd0;
              sio_o     <= adr_sr[23:20];
              adr_sr    <= {adr_sr[19:0], 4'h0};
              sio_oen_o <= 4'b1111;
            end else begin
              sio_o  <= {3'b000, cmd_sr[7]};
              cmd_sr <= {cmd_sr[6:0], 1'b0};
            end
          end
        end

        ADR: begin
          if (cnt[0]) begin
            if (cnt == 8'd11) begin
              cnt <= 8'd0;
              if (we_q) begin
                state  <= WDATA;
                sio_o  <= dat_sr[31:28];
                dat_sr <= {dat_sr[27:0], 4'h0};
              end else begin
                state     <= (DUMMY_CYCLES == 0) ? RDATA : DUMMY;
                sio_o     <= 4'b0000;
                sio_oen_o <= 4'b0000;
              end
            end else begin
              sio_o  <= adr_sr[23:20];
              adr_sr <= {adr_sr[19:0], 4'h0};
            end
          end
        end

        DUMMY: begin
          if (cnt[0] && (cnt == DUM_LAST)) begin
            state <= RDATA;
            cnt   <= 8'd0;
          end
        end

        WDATA: begin
          if (cnt[0]) begin
            if (cnt == 8'd15) begin
              state     <= GAP;
              cnt       <= 8'd0;
              cs_on     <= 1'b1;
              sio_o     <= 4'b0000;
              sio_oen_o <= 4'b0000;
              ack_o     <= 1'b1;
            end else begin
              sio_o  <= dat_sr[31:28];
              dat_sr <= {dat_sr[27:0], 4'h0};
            end
          end
        end

        RDATA: begin
          // Sample on the edge that takes sck from high to low.
          if (cnt[0]) begin
            rd_sr <= rd_full[27:0];
            if (cnt == 8'd15) begin
              state     <= GAP;
              cnt       <= 8'd0;
              cs_on     <= 1'b1;
              ack_o     <= 1'b1;
              rdat_o    <= {rd_full[7:0], rd_full[15:8], rd_full[23:16], rd_full[31:24]};
            end
          end
        end

        GAP: begin
          if (cnt == GAP_LAST) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            ready_o <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          state <= INIT;
          cnt   <= 8'd0;
          cs_on <= 1'b1;
          sck_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
